io_stall_req: RTL and testbench
===============================

IO_STALL_REQ -- requirements
Module: io_stall_req

Interface
REQ-001 SHALL have parameter DB_LIMIT, default 1_000_000, meaning cycles enter must stay stable before the debounced level changes (10 ms at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 500_000_000, meaning maximum wait in WAIT_PRESS; used only with IO_TIMEOUT_EN.
REQ-003 SHALL have ports:
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  reset: synchronous, active-high
- enter  in  1  raw asynchronous push-button
- sw_in  in  16  user switches
- io_rd_req  in  1  CPU requests a user-input read
- io_wr_req  in  1  CPU writes the output display
- io_wdata  in  32  write data
- stall_req_io  out  1  stall request to the pipeline controller
- io_rdata  out  32  read data
- io_rdata_valid  out  1  one-cycle pulse; io_rdata is valid
- led_out  out  16  display register
- waiting  out  1  high while waiting for the user
- timeout  out  1  sticky flag; read ended by timeout

Function
REQ-004 SHALL pass enter through a 2-flop synchronizer.
REQ-005 SHALL update debounced level enter_db to the synchronized value only after that value differs from enter_db for DB_LIMIT consecutive cycles.
- Any cycle where they match SHALL clear the counter.
REQ-006 SHALL define press as a 0->1 transition of enter_db, registered one cycle.
REQ-007 FSM states SHALL be IDLE, WAIT_RELEASE, WAIT_PRESS, DONE.
REQ-008 In IDLE with io_rd_req=1:
- if enter_db=1, next state SHALL be WAIT_RELEASE;
- otherwise next state SHALL be WAIT_PRESS.
REQ-009 WAIT_RELEASE SHALL go to WAIT_PRESS when enter_db=0, so a held button never satisfies a new read.
REQ-010 WAIT_PRESS on press SHALL:
- latch {16'b0, sw_in} into io_rdata;
- go to DONE.
REQ-011 DONE SHALL pulse io_rdata_valid=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-012 stall_req_io SHALL be combinational: (IDLE and io_rd_req) or WAIT_RELEASE or WAIT_PRESS.
- It SHALL be 0 in DONE.
- Stall therefore asserts in the same cycle the request arrives.
REQ-013 waiting SHALL equal (state is WAIT_RELEASE or WAIT_PRESS).
REQ-014 io_rd_req high in the cycle after DONE SHALL start a new, independent read.
REQ-015 io_wr_req=1 SHALL load io_wdata[15:0] into led_out at the next edge, in any state, without stalling.
- Simultaneous read and write SHALL both be served.
REQ-016 io_rdata SHALL hold its last value until the next capture.

Reset
REQ-017 With rst=1 at a clock edge, the following SHALL take effect:
- state=IDLE
- io_rdata=0, io_rdata_valid=0, led_out=0, timeout=0
- synchronizer flops, enter_db and all counters = 0
REQ-018 rst mid-wait SHALL abort the read with no valid pulse.
- stall_req_io SHALL drop after that edge unless io_rd_req is still high.

Configuration
REQ-019 Macro IO_TIMEOUT_EN, when defined, SHALL add a wait counter that clears on entry to WAIT_PRESS.
- On reaching TIMEOUT_CYCLES without a press, the block SHALL load io_rdata=0, set timeout=1 and go to DONE.
- timeout SHALL clear on the next successful press capture or on reset.
REQ-020 Without IO_TIMEOUT_EN:
- the counter SHALL be absent;
- timeout SHALL be tied to 0;
- WAIT_PRESS SHALL wait indefinitely.

Verification (DB_LIMIT=4, TIMEOUT_CYCLES=50)
REQ-021 Basic read: sw_in=16'hA5A5, io_rd_req=1, enter pressed for 10 cycles.
- stall_req_io=1 from the request cycle.
- Exactly one valid pulse with io_rdata=32'h0000A5A5; stall 0 in that cycle.
REQ-022 Bounce: enter toggled every 2 cycles for 20 cycles, then held low.
- enter_db stays 0; no capture; stall stays 1.
REQ-023 Held button: enter_db=1 when io_rd_req rises.
- State goes to WAIT_RELEASE; no capture until release followed by a new press.
REQ-024 Write: io_wr_req=1, io_wdata=32'h1234_BEEF in IDLE.
- led_out=16'hBEEF next cycle; stall_req_io=0.
REQ-025 Reset: rst asserted in WAIT_PRESS.
- All outputs 0; no valid pulse.
REQ-026 With IO_TIMEOUT_EN: read and no press.
- After 50 cycles: valid pulse, io_rdata=0, timeout=1.
- A subsequent successful read clears timeout.

Source files
------------

// File: rtl/io_stall_req.sv
// ---------------------------------------------------------------------------
// io_stall_req
//
// Memory-mapped user I/O for a pipelined CPU. A read of the user-input port
// stalls the pipeline until the operator presses the (debounced) enter button.
// The read then returns the switch value together with a one-cycle valid
// pulse. A write loads the LED display register and never stalls.
//
// Ports
//   clk            in   1   clock, rising edge
//   rst            in   1   synchronous, active-high reset
//   enter          in   1   raw asynchronous push-button
//   sw_in          in  16   user switches
//   io_rd_req      in   1   CPU requests a user-input read
//   io_wr_req      in   1   CPU writes the display register
//   io_wdata       in  32   write data (low 16 bits used)
//   stall_req_io   out  1   stall request to the pipeline controller
//   io_rdata       out 32   read data, held until the next capture
//   io_rdata_valid out  1   one-cycle pulse, io_rdata valid
//   led_out        out 16   display register
//   waiting        out  1   high while waiting for the operator
//   timeout        out  1   sticky: last read ended by timeout
//
// Optional feature
//   IO_TIMEOUT_EN  when defined, a read that sees no press within
//                  TIMEOUT_CYCLES cycles of WAIT_PRESS completes with
//                  io_rdata=0 and timeout=1. When undefined the wait is
//                  unbounded and timeout is tied low.
// ---------------------------------------------------------------------------
module io_stall_req #(
    parameter int DB_LIMIT       = 1_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enter,
    input  logic [15:0] sw_in,
    input  logic        io_rd_req,
    input  logic        io_wr_req,
    input  logic [31:0] io_wdata,
    output logic        stall_req_io,
    output logic [31:0] io_rdata,
    output logic        io_rdata_valid,
    output logic [15:0] led_out,
    output logic        waiting,
    output logic        timeout
);

    localparam int            DBW    = (DB_LIMIT > 1) ? $clog2(DB_LIMIT) : 1;
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RELEASE,
        ST_WAIT_PRESS,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [DBW-1:0]  r_db_cnt;
    logic            r_enter_db;
    logic            r_press;
    logic [31:0]     r_rdata;
    logic            r_valid;
    logic [15:0]     r_led;
    logic            w_unused;

    // Synchronizer, debouncer and press detector. The debounced level only
    // follows the synchronized input after DB_LIMIT consecutive disagreeing
    // cycles; r_press is a registered pulse marking the 0->1 update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= '0;
            r_enter_db <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_sync1 <= enter;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_enter_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_MAX) begin
                r_db_cnt   <= '0;
                r_enter_db <= r_sync2;
                r_press    <= r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + DBW'(1);
            end
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam int             TOW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TOW-1:0] TO_MAX = TOW'(TIMEOUT_CYCLES - 1);

    logic [TOW-1:0] r_to_cnt;
    logic           r_timeout;
`endif

    // Read FSM. io_rdata_valid is registered on the transition into DONE so
    // that it is high for exactly the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rdata <= '0;
            r_valid <= 1'b0;
`ifdef IO_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_rd_req) begin
                        // A button already held must be released first so a
                        // stale press never satisfies a new read.
                        if (r_enter_db) begin
                            r_state <= ST_WAIT_RELEASE;
                        end else begin
                            r_state <= ST_WAIT_PRESS;
`ifdef IO_TIMEOUT_EN
                            r_to_cnt <= '0;
`endif
                        end
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (!r_enter_db) begin
                        r_state <= ST_WAIT_PRESS;
`ifdef IO_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                ST_WAIT_PRESS: begin
                    if (r_press) begin
                        r_rdata <= {16'b0, sw_in};
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
`ifdef IO_TIMEOUT_EN
                        r_timeout <= 1'b0;
                    end else if (r_to_cnt == TO_MAX) begin
                        r_rdata   <= '0;
                        r_valid   <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TOW'(1);
`endif
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Display register: written in any state, independent of the read FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= '0;
        end else if (io_wr_req) begin
            r_led <= io_wdata[15:0];
        end
    end

    // Stall is combinational so it asserts in the same cycle as the request.
    assign stall_req_io   = ((r_state == ST_IDLE) && io_rd_req)
                          || (r_state == ST_WAIT_RELEASE)
                          || (r_state == ST_WAIT_PRESS);
    assign waiting        = (r_state == ST_WAIT_RELEASE) || (r_state == ST_WAIT_PRESS);
    assign io_rdata       = r_rdata;
    assign io_rdata_valid = r_valid;
    assign led_out        = r_led;

`ifdef IO_TIMEOUT_EN
    assign timeout  = r_timeout;
    assign w_unused = &{1'b0, io_wdata[31:16]};
`else
    assign timeout  = 1'b0;
    assign w_unused = &{1'b0, io_wdata[31:16], (TIMEOUT_CYCLES > 0)};
`endif

endmodule

// File: tb/tb_io_stall_req.sv
// ---------------------------------------------------------------------------
// tb_io_stall_req
//
// Bench for io_stall_req with DB_LIMIT=4, TIMEOUT_CYCLES=50. A transaction
// level reference (debounced button level, "read in progress / must release
// first / result due" flags) predicts every output each cycle; a directed
// prologue pins the reference with literal expectations, then random
// stimulus exercises bounces, overlapping writes and resets.
// ---------------------------------------------------------------------------
module tb_io_stall_req;

    localparam int DB = 4;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enter = 1'b0;
    logic [15:0] sw_in = 16'h0;
    logic        io_rd_req = 1'b0;
    logic        io_wr_req = 1'b0;
    logic [31:0] io_wdata = 32'h0;
    logic        stall_req_io;
    logic [31:0] io_rdata;
    logic        io_rdata_valid;
    logic [15:0] led_out;
    logic        waiting;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    io_stall_req #(
        .DB_LIMIT      (DB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enter         (enter),
        .sw_in         (sw_in),
        .io_rd_req     (io_rd_req),
        .io_wr_req     (io_wr_req),
        .io_wdata      (io_wdata),
        .stall_req_io  (stall_req_io),
        .io_rdata      (io_rdata),
        .io_rdata_valid(io_rdata_valid),
        .led_out       (led_out),
        .waiting       (waiting),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_ok = 1'b0;
    bit          m_seen1, m_seen2;   // raw button one and two edges ago
    bit          m_db;               // debounced level
    int          m_run;              // consecutive cycles seen value disagrees with m_db
    bit          m_press;            // rise of m_db happened at the last edge
    bit          m_busy;             // a read is stalled waiting for the operator
    bit          m_need_rel;         // the read still needs the button released
    bit          m_deliver;          // this cycle carries the result
    int          m_wait;             // cycles spent waiting for a press
    logic [31:0] m_rdata;
    logic [15:0] m_led;
    bit          m_to;

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1'b1;
            m_seen1 = 0; m_seen2 = 0; m_db = 0; m_run = 0; m_press = 0;
            m_busy = 0; m_need_rel = 0; m_deliver = 0; m_wait = 0;
            m_rdata = 32'h0; m_led = 16'h0; m_to = 0;
        end else begin
            if (m_deliver) begin
                m_deliver = 0;
            end else if (!m_busy) begin
                if (io_rd_req) begin
                    m_busy = 1; m_need_rel = m_db; m_wait = 0;
                end
            end else if (m_need_rel) begin
                if (!m_db) begin
                    m_need_rel = 0; m_wait = 0;
                end
            end else if (m_press) begin
                m_rdata = {16'h0, sw_in}; m_to = 0; m_busy = 0; m_deliver = 1;
            end else begin
                m_wait++;
`ifdef IO_TIMEOUT_EN
                if (m_wait == TO) begin
                    m_rdata = 32'h0; m_to = 1; m_busy = 0; m_deliver = 1;
                end
`endif
            end
            if (io_wr_req) m_led = io_wdata[15:0];
            m_press = 0;
            if (m_seen2 != m_db) begin
                m_run++;
                if (m_run == DB) begin
                    m_press = !m_db;
                    m_db = !m_db;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_seen2 = m_seen1;
            m_seen1 = enter;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            lit("m_stall",   32'(stall_req_io),   32'(m_busy || (!m_deliver && io_rd_req)));
            lit("m_waiting", 32'(waiting),        32'(m_busy));
            lit("m_valid",   32'(io_rdata_valid), 32'(m_deliver));
            lit("m_rdata",   io_rdata,            m_rdata);
            lit("m_led",     32'(led_out),        32'(m_led));
            lit("m_timeout", 32'(timeout),        32'(m_to));
        end
    end

    // ---------------- stimulus ----------------
    // Inputs only change 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, input logic [31:0] exp, input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            neg();
            if (io_rdata_valid === 1'b1) begin
                seen = 1;
                lit({tag, "_rdata"}, io_rdata, exp);
                lit({tag, "_stall_in_done"}, 32'(stall_req_io), 32'd0);
            end
            step();
        end
        lit({tag, "_valid_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            neg();
            if (io_rdata_valid === 1'b1) n++;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int hold;

        // Reset
        rst = 1'b1;
        repeat (3) step();
        neg();
        lit("rst_stall",   32'(stall_req_io),   32'd0);
        lit("rst_valid",   32'(io_rdata_valid), 32'd0);
        lit("rst_led",     32'(led_out),        32'd0);
        lit("rst_rdata",   io_rdata,            32'd0);
        lit("rst_waiting", 32'(waiting),        32'd0);
        lit("rst_timeout", 32'(timeout),        32'd0);
        step();
        rst = 1'b0;
        step();

        // Write in IDLE
        io_wr_req = 1'b1;
        io_wdata  = 32'h1234_BEEF;
        step();
        io_wr_req = 1'b0;
        neg();
        lit("wr_led",   32'(led_out),      32'h0000_BEEF);
        lit("wr_stall", 32'(stall_req_io), 32'd0);
        step();

        // Basic read
        sw_in     = 16'hA5A5;
        io_rd_req = 1'b1;
        neg();
        lit("rd_stall_same_cycle", 32'(stall_req_io), 32'd1);
        step();
        enter = 1'b1;
        wait_valid(30, 32'h0000_A5A5, "rd");
        io_rd_req = 1'b0;
        step();
        step();
        enter = 1'b0;
        count_valid(15, n);
        lit("rd_single_pulse", 32'(n), 32'd0);

        // Bounce: toggling every 2 cycles never settles
        sw_in     = 16'h0F0F;
        io_rd_req = 1'b1;
        step();
        n = 0;
        for (int i = 0; i < 30; i++) begin
            enter = (i < 20) ? ((i / 2) % 2 == 0) : 1'b0;
            neg();
            if (io_rdata_valid === 1'b1) n++;
            step();
        end
        lit("bounce_no_capture", 32'(n), 32'd0);
        neg();
        lit("bounce_stall",   32'(stall_req_io), 32'd1);
        lit("bounce_waiting", 32'(waiting),      32'd1);
        step();
        enter = 1'b1;
        wait_valid(20, 32'h0000_0F0F, "bounce_end");
        io_rd_req = 1'b0;
        step();
        enter = 1'b0;
        repeat (10) step();

        // Held button when the read arrives
        enter = 1'b1;
        repeat (10) step();
        sw_in     = 16'h3C3C;
        io_rd_req = 1'b1;
        step();
        count_valid(15, n);
        lit("held_no_capture", 32'(n), 32'd0);
        neg();
        lit("held_waiting", 32'(waiting), 32'd1);
        step();
        enter = 1'b0;
        count_valid(12, n);
        lit("release_no_capture", 32'(n), 32'd0);
        sw_in = 16'h7E81;
        enter = 1'b1;
        wait_valid(20, 32'h0000_7E81, "held_press");
        io_rd_req = 1'b0;
        step();
        enter = 1'b0;
        repeat (10) step();

        // Reset in WAIT_PRESS
        io_rd_req = 1'b1;
        io_wr_req = 1'b1;
        io_wdata  = 32'h0000_5555;
        step();
        io_wr_req = 1'b0;
        repeat (3) step();
        rst       = 1'b1;
        io_rd_req = 1'b0;
        step();
        rst = 1'b0;
        neg();
        lit("rstw_stall",   32'(stall_req_io),   32'd0);
        lit("rstw_waiting", 32'(waiting),        32'd0);
        lit("rstw_valid",   32'(io_rdata_valid), 32'd0);
        lit("rstw_led",     32'(led_out),        32'd0);
        lit("rstw_rdata",   io_rdata,            32'd0);
        step();
        count_valid(8, n);
        lit("rstw_no_pulse", 32'(n), 32'd0);

`ifdef IO_TIMEOUT_EN
        // No press: read completes by timeout, then a real press clears it
        sw_in     = 16'hFFFF;
        io_rd_req = 1'b1;
        step();
        wait_valid(60, 32'h0, "to");
        io_rd_req = 1'b0;
        neg();
        lit("to_flag", 32'(timeout), 32'd1);
        step();
        io_rd_req = 1'b1;
        sw_in     = 16'h1357;
        step();
        enter = 1'b1;
        wait_valid(20, 32'h0000_1357, "to_clear");
        io_rd_req = 1'b0;
        neg();
        lit("to_cleared", 32'(timeout), 32'd0);
        step();
        enter = 1'b0;
        repeat (10) step();
`endif

        // Randomized phase, checked cycle by cycle against the model
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            io_rd_req = ($urandom_range(0, 99) < 40);
            io_wr_req = ($urandom_range(0, 99) < 20);
            io_wdata  = $urandom;
            sw_in     = 16'($urandom);
            if (hold == 0) begin
                if ($urandom_range(0, 9) < 7) enter = ~enter;
                hold = $urandom_range(1, 12);
            end else begin
                hold--;
            end
            step();
        end
        rst       = 1'b0;
        io_rd_req = 1'b0;
        io_wr_req = 1'b0;
        step();
        neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
